// File: rtl/rv_divider_iter.sv
// rv_divider_iter: iterative restoring integer divider for RV32M/RV64M.
// Supports DIV, DIVU, REM and REMU with the RISC-V results for divide by
// zero and for signed overflow. Uses a start/ready/valid handshake and a
// kill input for pipeline flush.
// Optional build macro DIV_FAST_SPECIAL_EN: divide by zero and signed
// overflow skip the iteration and finish with a latency of 1.
//
// state | meaning
// IDLE  | ready for a request; ready_o=1
// CALC  | one restoring step per cycle on the operand magnitudes
// DONE  | result_o holds the answer; valid_o pulses unless killed
module rv_divider_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dsr_q, dsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              signed_op;
    logic              a_neg, b_neg;
    logic [XLEN:0]     a_mag, b_mag;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   step_rem, step_quo;
    logic [XLEN-1:0]   quo_res, rem_res, calc_res;

`ifdef DIV_FAST_SPECIAL_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic              is_dz, is_ovf;
    logic [XLEN-1:0]   special_res;
`endif

    // Operand magnitudes in XLEN+1 bits so |-2^(XLEN-1)| is representable,
    // plus one restoring step and the sign-fixed final result.
    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & dividend_i[XLEN-1];
        b_neg     = signed_op & divisor_i[XLEN-1];
        a_mag     = a_neg ? ((XLEN+1)'(0) - {dividend_i[XLEN-1], dividend_i})
                          : {1'b0, dividend_i};
        b_mag     = b_neg ? ((XLEN+1)'(0) - {divisor_i[XLEN-1], divisor_i})
                          : {1'b0, divisor_i};

        trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
        step_rem  = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
        step_quo  = {quo_q[XLEN-2:0], ~trial[XLEN]};

        // Divide by zero overrides the magnitude result entirely.
        quo_res   = dz_q ? '1    : (qneg_q ? (XLEN'(0) - step_quo) : step_quo);
        rem_res   = dz_q ? dvd_q : (rneg_q ? (XLEN'(0) - step_rem) : step_rem);
        calc_res  = op_q[1] ? rem_res : quo_res;
    end

`ifdef DIV_FAST_SPECIAL_EN
    // Early detection of the two architected special cases.
    always_comb begin
        is_dz       = (divisor_i == '0);
        is_ovf      = signed_op && (dividend_i == MIN_NEG) && (divisor_i == '1);
        special_res = is_dz ? (op_i[1] ? dividend_i : '1)
                            : (op_i[1] ? '0 : MIN_NEG);
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    op_d    = op_i;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = (divisor_i == '0);
                    dvd_d   = dividend_i;
                    rem_d   = '0;
                    quo_d   = a_mag[XLEN-1:0];
                    dsr_d   = b_mag[XLEN-1:0];
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_FAST_SPECIAL_EN
                    if (is_dz || is_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        cnt_d    = '0;
                        result_d = calc_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            dvd_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q == S_CALC) || (state_q == S_DONE);
    assign valid_o  = (state_q == S_DONE) && !kill_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_rv_divider_iter.sv
// Directed testbench for rv_divider_iter (XLEN=32).
module tb_rv_divider_iter;

    localparam int XLEN = 32;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            kill_i;
    logic            ready_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    int checks = 0;
    int errors = 0;

    rv_divider_iter #(.XLEN(XLEN)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .kill_i     (kill_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        bit              special;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for valid_o; lat counts edges from the acceptance edge inclusive.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    // Issue one request and wait for acceptance; returns just after edge E0.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n = 0;
        while (ready_o !== 1'b1 && n < 60) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(negedge clk_i);
        op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        int lat;
        bit ok;
        issue(op, a, b);
        wait_valid(lat, ok);
        check({name, " valid"}, ok, 1);
        if (ok) begin
            check({name, " result"}, result_o, exp);
            check({name, " latency"}, lat, exp_lat);
            @(posedge clk_i); #1;
            check({name, " valid one cycle"}, valid_o, 0);
            check({name, " ready after"}, ready_o, 1);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        bit ok;
        int seen;

        vecs.push_back('{DIVU, 32'd100,        32'd7,          32'd14,         0});
        vecs.push_back('{REMU, 32'd100,        32'd7,          32'd2,          0});
        vecs.push_back('{DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   0});
        vecs.push_back('{REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   0});
        vecs.push_back('{DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   0});
        vecs.push_back('{REM,  32'd7,          32'hFFFFFFFE,   32'd1,          0});
        vecs.push_back('{DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1});
        vecs.push_back('{REMU, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1});
        vecs.push_back('{REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1});
        vecs.push_back('{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
        vecs.push_back('{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1});
        vecs.push_back('{DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          0});
        vecs.push_back('{REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0});
        vecs.push_back('{DIV,  32'h80000000,   32'd2,          32'hC0000000,   0});
        vecs.push_back('{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   0});
        vecs.push_back('{REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   0});

        rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = '0;
        dividend_i = '0; divisor_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset ready", ready_o, 1);
        check("reset busy", busy_o, 0);
        check("reset valid", valid_o, 0);
        check("reset result", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].special ? SP_LAT : 33);
        end

        // Kill at CALC step 10: no result, ready next cycle, result_o kept.
        issue(DIVU, 32'd1000, 32'd3);
        check("kill busy", busy_o, 1);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        check("kill ready", ready_o, 1);
        check("kill busy off", busy_o, 0);
        check("kill result kept", result_o, 32'hFFFFFFFE);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o === 1'b1) seen++;
            @(posedge clk_i); #1;
        end
        check("kill no valid", seen, 0);
        run_op("after kill 9/4", DIVU, 32'd9, 32'd4, 32'd2, 33);
        run_op("divu 1000/3", DIVU, 32'd1000, 32'd3, 32'd333, 33);

        // Reset mid-op.
        issue(DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rst ready", ready_o, 1);
        check("rst busy", busy_o, 0);
        check("rst valid", valid_o, 0);
        check("rst result", result_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o === 1'b1) seen++;
            @(posedge clk_i); #1;
        end
        check("rst no valid", seen, 0);

        // start_i held high with a different op during CALC.
        @(negedge clk_i);
        op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i); #1;
        dividend_i = 32'd50; divisor_i = 32'd5;
        wait_valid(lat, ok);
        check("held first valid", ok, 1);
        check("held first result", result_o, 32'd14);
        check("held first latency", lat, 33);
        @(posedge clk_i); #1;
        check("held ready", ready_o, 1);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("held second accepted", busy_o, 1);
        wait_valid(lat, ok);
        check("held second valid", ok, 1);
        check("held second result", result_o, 32'd10);
        check("held second latency", lat, 33);
        @(posedge clk_i); #1;
        check("held idle", ready_o, 1);

        // kill_i together with start_i in IDLE: not accepted.
        @(negedge clk_i);
        op_i = DIVU; dividend_i = 32'd9; divisor_i = 32'd4; start_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; kill_i = 1'b0;
        check("start+kill ignored", ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rv_divider_iter.md
Name: rv_divider_iter

Overview:
- Parametrised iterative integer divider for the RV32M/RV64M execute stage. Successor to the fixed 32-bit unsigned restoring divider.
- Adds signed and unsigned quotient/remainder ops (DIV, DIVU, REM, REMU) with RISC-V-exact divide-by-zero and overflow results.
- Adds a start/ready/valid handshake and a pipeline-flush kill.
- Sits beside the multiplier behind the M-extension result mux. The core stalls issue while busy_o=1.

Parameters:
- XLEN, 32, operand/result width. Legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, do not override).

Ports:
- clk_i  input  1  core clock, rising edge
- rst_i  input  1  synchronous reset, active-high
- start_i  input  1  request. Accepted only when ready_o=1.
- op_i  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  XLEN  rs1, sampled on the acceptance edge
- divisor_i  input  XLEN  rs2, sampled on the acceptance edge
- kill_i  input  1  flush: abort the in-flight op, produce no result
- ready_o  output  1  high only in IDLE
- busy_o  output  1  high in CALC or DONE
- valid_o  output  1  one-cycle result strobe
- result_o  output  XLEN  quotient or remainder, per the latched op

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, counter=0, all datapath registers=0. Reset mid-op discards the op.
- States and transitions:
  - IDLE: if start_i && !kill_i, latch op, operand signs, |dividend|, |divisor|; go to CALC. Special case handled under Optional Feature.
  - CALC: one restoring step per cycle on magnitudes. Trial = {rem,next bit} - divisor. If non-negative, accept it and shift in quotient bit 1; else keep rem and shift in 0. Counter runs 0..XLEN-1; after step XLEN-1 go to DONE.
  - DONE: valid_o=1 for exactly this cycle; next state IDLE unconditionally.
- Latency: acceptance edge E0, XLEN CALC edges, valid_o high during the cycle after edge E0+XLEN. For XLEN=32, valid_o is high 33 cycles after E0; ready_o returns 1 the following cycle.
- Sign fix (signed ops only): quotient negated when the operand signs differ. Remainder takes the dividend's sign. Magnitudes use XLEN+1-bit arithmetic so |-2^(XLEN-1)| is representable.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend_i unmodified.
- Signed overflow (DIV/REM, dividend=-2^(XLEN-1), divisor=-1): quotient=-2^(XLEN-1), remainder=0.
- result_o is registered, written on entry to DONE, and held until the next entry to DONE. It is not cleared on kill.
- start_i while ready_o=0 is ignored, with no queueing.
- kill_i in CALC or DONE: next state IDLE; valid_o is not asserted (kill in DONE masks valid_o combinationally that cycle). kill_i and start_i together in IDLE: the request is not accepted.
- Operand inputs need not be held after acceptance.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: divide by zero and signed overflow are detected in IDLE on acceptance and go straight to DONE with the architected result. valid_o is high the cycle after E0 (latency 1).
- Undefined: these cases run the full XLEN-step CALC sequence with identical latency to normal ops. Sign-fix and override logic still yield the same architected results.
- Results are bit-identical either way; only latency differs.

Test Plan:
- DIVU 100/7 (XLEN=32) -> result_o=14, valid_o exactly 33 cycles after acceptance; REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD; REM -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; latency 33 without DIV_FAST_SPECIAL_EN, 1 with it.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU 1000/3 with kill_i pulsed at CALC step 10 -> no valid_o, ready_o=1 next cycle; then DIVU 9/4 -> 2 with normal latency. Repeat using rst_i instead of kill -> all outputs at reset values.
- start_i held high with a new op during CALC -> ignored; first result unchanged; second op accepted only once ready_o=1.
